led_on: RTL and testbench

- Board-level LED driver for an 8-LED bank; after reset it drives a fixed, parameterised on-pattern onto the LEDs.
- Includes a post-reset startup blanking interval and a global PWM brightness stage.
- Top-level leaf block; its only output goes straight to the board LED pins (led[0] = LED0 … led[7] = LED7).
- With default parameters, all eight LEDs are steadily on once startup completes.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_pwm.sv | 61 ++++++
 rtl/led_on.sv | 69 ++++++
 tb/tb_led_on.sv | 118 +++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED-bank types and constants for the board LED driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pkg;

  localparam int LED_COUNT = 8;

  typedef logic [LED_COUNT-1:0] led_vec_t;

  localparam led_vec_t LED_ALL_ON  = 8'hFF;
  localparam led_vec_t LED_ALL_OFF = 8'h00;

  // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with a fixed duty compare for global LED brightness.
// Latency: on is combinational from the registered counter; counter steps once per clock while en=1.
// Backpressure: none; counter is held at 0 while en=0.
//
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   en  - run enable; counter held at 0 while low
//   on  - PWM on-phase indicator
module led_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int DUTY     = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic on
);

  localparam int CNT_MAX = (1 << PWM_BITS) - 1;

  // Degenerate duties are resolved at elaboration so the compare never sees them.
  localparam bit ALWAYS_OFF = (DUTY <= 0);
  localparam bit ALWAYS_ON  = (DUTY >= CNT_MAX);
  localparam logic [PWM_BITS-1:0] DUTY_V = PWM_BITS'(DUTY);

  if (PWM_BITS < 1 || PWM_BITS > 16) begin : g_bad_pwm_bits
    $fatal(1, "led_pwm: PWM_BITS=%0d outside 1..16", PWM_BITS);
  end

  if (DUTY > CNT_MAX) begin : g_duty_clip
    $warning("led_pwm: DUTY=%0d exceeds counter max %0d, treated as always on", DUTY, CNT_MAX);
  end

  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = en ? (cnt_q + PWM_BITS'(1)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    if (ALWAYS_OFF) begin
      on = 1'b0;
    end else if (ALWAYS_ON) begin
      on = 1'b1;
    end else begin
      on = (cnt_q < DUTY_V);
    end
  end

endmodule

// File: rtl/led_on.sv
// Board LED driver: startup blanking, then a fixed on-pattern gated by global PWM.
// Latency: led first shows PATTERN at edge STARTUP_CYCLES+1 after reset release (edge 1 if no blanking).
// Backpressure: none; free-running output straight to the LED pins.
//
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset; forces led to 0 immediately
//   led - registered active-high LED drive, led[i] = LEDi
module led_on
  import led_pkg::*;
#(
  parameter logic [7:0] PATTERN        = LED_ALL_ON,
  parameter int         PWM_BITS       = 8,
  parameter int         DUTY           = 255,
  parameter int         STARTUP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [LED_COUNT-1:0] led
);

  localparam int SW = cnt_width(STARTUP_CYCLES);
  localparam logic [SW-1:0] START_MAX = SW'(STARTUP_CYCLES);

  logic [SW-1:0] start_cnt_q, start_cnt_d;
  logic          enable_q, enable_d;
  logic          run;
  logic          pwm_on;
  led_vec_t      led_q, led_d;

  // Startup counter saturates at START_MAX; enable latches the first time it gets there.
  always_comb begin
    start_cnt_d = (start_cnt_q == START_MAX) ? start_cnt_q : (start_cnt_q + SW'(1));
    enable_d    = enable_q | (start_cnt_d == START_MAX);
  end

  // With no blanking the bank must light on the very first edge, which the
  // registered flag (cleared by reset) cannot provide, so bypass it.
  assign run = enable_q | (STARTUP_CYCLES == 0);

  always_comb begin
    led_d = (run && pwm_on) ? PATTERN : LED_ALL_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt_q <= '0;
      enable_q    <= 1'b0;
      led_q       <= LED_ALL_OFF;
    end else begin
      start_cnt_q <= start_cnt_d;
      enable_q    <= enable_d;
      led_q       <= led_d;
    end
  end

  led_pwm #(
    .PWM_BITS (PWM_BITS),
    .DUTY     (DUTY)
  ) u_pwm (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .on  (pwm_on)
  );

  assign led = led_q;

endmodule

// File: tb/tb_led_on.sv
// Directed testbench for led_on across four parameterisations sharing clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_on;

  logic       clk;
  logic       rst;
  logic [7:0] led_def;
  logic [7:0] led_pat;
  logic [7:0] led_pwm3;
  logic [7:0] led_off;

  int n_checks = 0;
  int n_errors = 0;

  // Defaults: PATTERN=FF, PWM_BITS=8, DUTY=255, STARTUP_CYCLES=4
  led_on u_def (
    .clk (clk),
    .rst (rst),
    .led (led_def)
  );

  led_on #(.PATTERN(8'h01), .STARTUP_CYCLES(0)) u_pat (
    .clk (clk),
    .rst (rst),
    .led (led_pat)
  );

  led_on #(.PWM_BITS(3), .DUTY(3), .STARTUP_CYCLES(0)) u_pwm3 (
    .clk (clk),
    .rst (rst),
    .led (led_pwm3)
  );

  led_on #(.DUTY(0)) u_off (
    .clk (clk),
    .rst (rst),
    .led (led_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected values for edge k after reset release (k=1 is the first edge).
  task automatic check_all(input int k);
    logic [7:0] exp_def;
    logic [7:0] exp_pwm3;
    exp_def  = (k <= 4) ? 8'h00 : 8'hFF;
    exp_pwm3 = (((k - 1) % 8) < 3) ? 8'hFF : 8'h00;
    check($sformatf("def_edge%0d", k), led_def, exp_def);
    check($sformatf("pat_edge%0d", k), led_pat, 8'h01);
    check($sformatf("pwm3_edge%0d", k), led_pwm3, exp_pwm3);
    check($sformatf("off_edge%0d", k), led_off, 8'h00);
  endtask

  initial begin
    rst = 1'b1;

    // Reset state before any clock edge.
    #1;
    check("rst_pre_def", led_def, 8'h00);
    check("rst_pre_pat", led_pat, 8'h00);
    check("rst_pre_pwm3", led_pwm3, 8'h00);
    check("rst_pre_off", led_off, 8'h00);

    // Held in reset for 3 edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst_hold%0d_def", i), led_def, 8'h00);
      check($sformatf("rst_hold%0d_pat", i), led_pat, 8'h00);
      check($sformatf("rst_hold%0d_pwm3", i), led_pwm3, 8'h00);
    end

    // Release away from a clock edge, then follow 1000 edges.
    rst = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_all(k);
    end

    // Asynchronous reset mid-cycle: led must drop before the next edge.
    @(posedge clk);
    #2;
    check("pre_async_def", led_def, 8'hFF);
    rst = 1'b1;
    #1;
    check("async_drop_def", led_def, 8'h00);
    check("async_drop_pat", led_pat, 8'h00);
    check("async_drop_pwm3", led_pwm3, 8'h00);
    @(negedge clk);
    check("async_hold_def", led_def, 8'h00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full startup sequence repeats after release.
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_all(k);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
